axis_i2c_slave: RTL and testbench

I2C target (slave) endpoint that responds to a single 7-bit address on an open-drain bus and bridges bus traffic to AXI-Stream. Bytes written by a bus master are emitted on an AXIS master port; bytes read by a bus master are pulled from an AXIS slave port. It sits opposite `axis_i2c_master`, on the bus, in the same clock domain style. It is used both as a bus-functional peripheral in simulation and as an on-chip target.

---
 rtl/axis_i2c_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_axis_i2c_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_slave.sv
`default_nettype none
// ============================================================================
// axis_i2c_slave : I2C target bridging bus writes to m_axis and reads to s_axis
// Rev 1.0 | optional feature macro: I2C_GENERAL_CALL_EN (ACK write to 7'h00)
// ============================================================================
module axis_i2c_slave #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  i2c_scl_i,
  inout  wire                   i2c_sda_io,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_IGNORE
  } state_e;

  logic [1:0]            scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            sh_q, sh_d;
  logic                  rw_q, rw_d;
  logic                  ack_q, ack_d;
  logic                  ninth_q, ninth_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;

  logic       w_scl, w_sda;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_rx_byte, w_tx_byte;
  logic       w_addr_hit, w_gc_hit, w_slot_free;
  logic       w_rx_load, w_tx_load;

  assign w_scl      = scl_sync_q[1];
  assign w_sda      = sda_sync_q[1];
  assign w_scl_rise = w_scl & ~scl_prev_q;
  assign w_scl_fall = ~w_scl & scl_prev_q;
  assign w_start    = w_scl & scl_prev_q & ~w_sda & sda_prev_q;
  assign w_stop     = w_scl & scl_prev_q & w_sda & ~sda_prev_q;

  assign w_rx_byte   = {sh_q[6:0], w_sda};
  assign w_tx_byte   = s_axis_tvalid_i ? s_axis_tdata_i[7:0] : 8'hFF;
  assign w_addr_hit  = (sh_q[6:0] == SLAVE_ADDR);
  assign w_slot_free = ~m_tvalid_q | m_axis_tready_i;

`ifdef I2C_GENERAL_CALL_EN
  assign w_gc_hit = (sh_q[6:0] == 7'h00) & ~w_sda;
`else
  assign w_gc_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    ninth_d   = ninth_q;
    sda_oe_d  = sda_oe_q;
    w_rx_load = 1'b0;
    w_tx_load = 1'b0;

    if (w_stop) begin
      state_d  = S_IDLE;
      cnt_d    = 4'd0;
      ninth_d  = 1'b0;
      sda_oe_d = 1'b0;
    end else if (w_start) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      ninth_d  = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (w_scl_rise) begin
            sh_d  = w_rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (w_addr_hit || w_gc_hit) begin
                state_d = S_ADDR_ACK;
                rw_d    = w_sda;
                ack_d   = 1'b1;
              end else begin
                state_d = S_IGNORE;
                cnt_d   = 4'd0;
              end
            end
          end
        end

        S_ADDR_ACK, S_RX_ACK: begin
          // First fall drives the ACK/NACK bit, the fall after the 9th rise closes it.
          if (w_scl_rise) begin
            ninth_d = 1'b1;
          end else if (w_scl_fall) begin
            if (!ninth_q) begin
              sda_oe_d = ack_q;
            end else begin
              ninth_d  = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == S_RX_ACK) begin
                state_d = ack_q ? S_RX : S_IGNORE;
              end else if (rw_q) begin
                w_tx_load = 1'b1;
                sh_d      = {w_tx_byte[6:0], 1'b1};
                sda_oe_d  = ~w_tx_byte[7];
                state_d   = S_TX;
              end else begin
                state_d = S_RX;
              end
            end
          end
        end

        S_RX: begin
          if (w_scl_rise) begin
            sh_d  = w_rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ack_d     = w_slot_free;
              w_rx_load = w_slot_free;
              state_d   = S_RX_ACK;
            end
          end
        end

        S_TX: begin
          if (w_scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (w_scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_TX_ACK;
            end else begin
              sda_oe_d = ~sh_q[7];
              sh_d     = {sh_q[6:0], 1'b1};
            end
          end
        end

        S_TX_ACK: begin
          // Only a master ACK keeps us here long enough to see the closing fall.
          if (w_scl_rise) begin
            if (w_sda) begin
              state_d = S_IGNORE;
              cnt_d   = 4'd0;
            end
          end else if (w_scl_fall) begin
            w_tx_load = 1'b1;
            sh_d      = {w_tx_byte[6:0], 1'b1};
            sda_oe_d  = ~w_tx_byte[7];
            cnt_d     = 4'd0;
            state_d   = S_TX;
          end
        end

        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    if (m_tvalid_q && m_axis_tready_i) begin
      m_tvalid_d = 1'b0;
    end
    if (w_rx_load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = DATA_WIDTH'(w_rx_byte);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'd0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ninth_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl_i};
      sda_sync_q <= {sda_sync_q[0], i2c_sda_io};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      ninth_q    <= ninth_d;
      sda_oe_q   <= sda_oe_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign i2c_sda_io      = sda_oe_q ? 1'b0 : 1'bz;
  assign m_axis_tdata_o  = m_tdata_q;
  assign m_axis_tvalid_o = m_tvalid_q;
  assign s_axis_tready_o = w_tx_load & s_axis_tvalid_i;

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_slave.sv
`default_nettype none
// ============================================================================
// tb_axis_i2c_slave : bus-master BFM with queue scoreboard for axis_i2c_slave
// Rev 1.0
// ============================================================================
module tb_axis_i2c_slave;

  localparam logic [6:0] ADDR = 7'h3C;
  localparam int         Q    = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arstn;
  logic       m_scl;
  logic       m_sda_oe;
  wire        sda_bus;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_tready;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  axis_i2c_slave #(.DATA_WIDTH(8), .SLAVE_ADDR(ADDR)) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .i2c_scl_i      (m_scl),
    .i2c_sda_io     (sda_bus),
    .m_axis_tdata_o (m_tdata),
    .m_axis_tvalid_o(m_tvalid),
    .m_axis_tready_i(m_tready),
    .s_axis_tdata_i (s_data),
    .s_axis_tvalid_i(s_valid),
    .s_axis_tready_o(s_tready)
  );

  int         vectors = 0;
  int         errors  = 0;
  int         pulses  = 0;
  logic [7:0] exp_m[$];
  logic [7:0] src[$];
  bit         model_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every m_axis handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (arstn && m_tvalid && m_tready) begin
      if (exp_m.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL m_axis_unexpected: got %0h expected no transfer", m_tdata);
      end else begin
        chk("m_axis_tdata", {24'd0, m_tdata}, int'(exp_m.pop_front()));
      end
    end
  end

  // s_axis source: consumes the head on each handshake.
  always @(posedge clk) begin
    if (s_tready && s_valid) begin
      pulses++;
      void'(src.pop_front());
    end
  end

  always @(negedge clk) begin
    s_valid = (src.size() > 0);
    s_data  = (src.size() > 0) ? src[0] : 8'h00;
  end

  // ---------------- bus-master BFM ----------------
  task automatic set_sda(input bit v);
    m_sda_oe = ~v;
  endtask

  task automatic clk_bit(input bit v, output bit r);
    set_sda(v); #Q;
    m_scl = 1'b1; #Q;
    r = sda_bus; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    set_sda(1'b1); #Q;
    m_scl = 1'b1; #Q;
    set_sda(1'b0); #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    set_sda(1'b0); #Q;
    m_scl = 1'b1; #Q;
    set_sda(1'b1); #Q;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    bit r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] b);
    bit r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      b = {b[6:0], r};
    end
    clk_bit(~ack, r);
  endtask

  // ---------------- reference model ----------------
  function automatic bit addr_acks(input logic [6:0] a, input bit rw);
    bit gc = 1'b0;
`ifdef I2C_GENERAL_CALL_EN
    gc = 1'b1;
`endif
    return (a == ADDR) || (gc && a == 7'h00 && !rw);
  endfunction

  task automatic drain();
    for (int k = 0; k < 200 && exp_m.size() > 0; k++) #10;
    chk("m_axis_drain", exp_m.size(), 0);
    exp_m.delete();
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] d[4], input bit rdy);
    bit ack;
    bit exp_ack;
    m_tready = rdy;
    if (rdy) model_full = 1'b0;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    exp_ack = addr_acks(a, 1'b0);
    chk("addr_ack", ack, exp_ack);
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        exp_ack = ~model_full;
        if (exp_ack) begin
          exp_m.push_back(d[i]);
          if (!rdy) model_full = 1'b1;
        end
        write_byte(d[i], ack);
        chk("data_ack", ack, exp_ack);
        if (!exp_ack) break;
      end
    end else begin
      write_byte(d[0], ack);
      chk("ignored_byte_ack", ack, 0);
    end
    i2c_stop();
    if (rdy) drain();
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input int k, input logic [7:0] d[4]);
    bit         ack;
    bit         exp_ack;
    logic [7:0] b;
    int         p0;
    int         exp_p;
    for (int i = 0; i < k; i++) src.push_back(d[i]);
    #20;
    p0 = pulses;
    i2c_start();
    write_byte({a, 1'b1}, ack);
    exp_ack = addr_acks(a, 1'b1);
    chk("rd_addr_ack", ack, exp_ack);
    exp_p = 0;
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, b);
        chk("rd_data", {24'd0, b}, (i < k) ? int'(d[i]) : 32'hFF);
      end
      exp_p = (n < k) ? n : k;
    end
    i2c_stop();
    chk("s_tready_pulses", pulses - p0, exp_p);
    src.delete();
  endtask

  logic [7:0] d[4];

  initial begin
    arstn    = 1'b0;
    m_scl    = 1'b1;
    m_sda_oe = 1'b0;
    m_tready = 1'b0;
    #47;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_sda", sda_bus, 1);
    arstn = 1'b1;
    #100;

    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    do_write(ADDR, 2, d, 1'b1);
    do_write(7'h3D, 1, d, 1'b1);

    d = '{8'hC3, 8'h3C, 8'h00, 8'h00};
    do_read(ADDR, 2, 2, d);
    do_read(ADDR, 1, 0, d);

    d = '{8'hA5, 8'h11, 8'h00, 8'h00};
    do_write(ADDR, 2, d, 1'b0);
    chk("held_tdata", m_tdata, 8'hA5);
    chk("held_tvalid", m_tvalid, 1);
    m_tready   = 1'b1;
    model_full = 1'b0;
    drain();

    d = '{8'h42, 8'h00, 8'h00, 8'h00};
    do_write(7'h00, 1, d, 1'b1);

    // Asynchronous reset while the target drives a 0 data bit.
    begin
      bit ack;
      src.push_back(8'h00);
      #20;
      i2c_start();
      write_byte({ADDR, 1'b1}, ack);
      chk("rst_rd_addr_ack", ack, 1);
      chk("tx_bit_low", sda_bus, 0);
      arstn = 1'b0;
      #1;
      chk("sda_async_release", sda_bus, 1);
      chk("rst_mid_tvalid", m_tvalid, 0);
      #9;
      arstn = 1'b1;
      i2c_stop();
      src.delete();
      exp_m.delete();
      model_full = 1'b0;
    end

    for (int t = 0; t < 25; t++) begin
      logic [6:0] a;
      int         sel;
      sel = $urandom_range(0, 9);
      a   = (sel == 0) ? 7'($urandom) : ((sel == 1) ? 7'h00 : ADDR);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom_range(1, 3), d, ($urandom_range(0, 2) != 0));
      end else begin
        do_read(a, $urandom_range(1, 3), $urandom_range(0, 3), d);
      end
    end

    m_tready   = 1'b1;
    model_full = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
